// File: rtl/rot_arb_seq.sv
// Round-robin arbitrated rotate-right unit: rotates the low FIELD_W bits of A by B,
// one bit per cycle, or in a single cycle when ROT_FASTPATH_EN is defined.
module rot_arb_seq #(
  parameter int DATA_W  = 32,
  parameter int FIELD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_id,
  output logic              busy
);

  localparam int CNT_W = $clog2(FIELD_W);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROTATE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   work_q, work_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                id_q, id_d;
  logic                ptr_q, ptr_d;

  logic                grant_s;
  logic                accept_s;
  logic [DATA_W-1:0]   sel_a_s;
  logic [DATA_W-1:0]   sel_b_s;
  logic                in_range_s;
  logic [CNT_W-1:0]    amt_s;

`ifdef ROT_FASTPATH_EN
  function automatic logic [FIELD_W-1:0] rotr_field(input logic [FIELD_W-1:0] f,
                                                    input logic [CNT_W-1:0]   n);
    logic [FIELD_W-1:0] r;
    r = f;
    for (int i = 0; i < FIELD_W; i++) begin
      r[i] = f[(i + int'(n)) % FIELD_W];
    end
    return r;
  endfunction
`endif

  // Pointer only breaks ties; a lone valid requester always wins.
  assign grant_s    = (req0_valid && req1_valid) ? ptr_q : req1_valid;
  assign accept_s   = (state_q == ST_IDLE) && (req0_valid || req1_valid);
  assign sel_a_s    = grant_s ? req1_a : req0_a;
  assign sel_b_s    = grant_s ? req1_b : req0_b;
  assign in_range_s = (sel_b_s < DATA_W'(FIELD_W));
  assign amt_s      = sel_b_s[CNT_W-1:0];

  assign req0_ready = !rst && (state_q == ST_IDLE) && req0_valid && !grant_s;
  assign req1_ready = !rst && (state_q == ST_IDLE) && req1_valid &&  grant_s;
  assign rsp_valid  = (state_q == ST_DONE);
  assign rsp_data   = work_q;
  assign rsp_id     = id_q;
  assign busy       = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          work_d = sel_a_s;
          id_d   = grant_s;
          ptr_d  = ~grant_s;
`ifdef ROT_FASTPATH_EN
          if (in_range_s) begin
            work_d[FIELD_W-1:0] = rotr_field(sel_a_s[FIELD_W-1:0], amt_s);
          end else begin
            work_d[FIELD_W-1:0] = sel_a_s[FIELD_W-1:0];
          end
          cnt_d   = '0;
          state_d = ST_DONE;
`else
          cnt_d = in_range_s ? amt_s : '0;
          if (in_range_s && (amt_s != '0)) begin
            state_d = ST_ROTATE;
          end else begin
            state_d = ST_DONE;
          end
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ROTATE: begin
        work_d = {work_q[DATA_W-1:FIELD_W], work_q[0], work_q[FIELD_W-1:1]};
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_ROTATE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      id_q    <= 1'b0;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_rot_arb_seq.sv
// Self-checking bench for rot_arb_seq: directed plan steps plus random operations
// checked against an arithmetic rotate / round-robin reference model.
module tb_rot_arb_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0v, r1v;
  logic [31:0] r0a, r0b, r1a, r1b;
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [31:0] rsp_data;

  int errors = 0;
  int checks = 0;
  bit ptr_m  = 1'b0;

`ifdef ROT_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  rot_arb_seq #(.DATA_W(32), .FIELD_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (r0v),
    .req0_ready (req0_ready),
    .req0_a     (r0a),
    .req0_b     (r0b),
    .req1_valid (r1v),
    .req1_ready (req1_ready),
    .req1_a     (r1a),
    .req1_b     (r1b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_rot(input logic [31:0] a, input logic [31:0] b);
    logic [15:0] dbl;
    if (b >= 32'd8) return a;
    dbl = {a[7:0], a[7:0]} >> b;
    return {a[31:8], dbl[7:0]};
  endfunction

  function automatic int exp_lat(input logic [31:0] b);
    if (FAST || b >= 32'd8) return 1;
    return int'(b) + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Caller sets the requester inputs just after a rising edge; one operation is served.
  task automatic serve(input int stall);
    int          g_exp, g_obs, lat, waitc;
    logic [31:0] a, b;
    g_exp = (r0v && r1v) ? int'(ptr_m) : (r0v ? 0 : 1);
    #1;
    waitc = 0;
    while (!(req0_ready || req1_ready) && waitc < 20) begin
      @(posedge clk); #1; waitc++;
    end
    chk("grant_wait", 32'(waitc < 20), 32'd1);
    chk("one_ready", 32'(req0_ready && req1_ready), 32'd0);
    g_obs = req1_ready ? 1 : 0;
    chk("grant_id", 32'(g_obs), 32'(g_exp));
    a = g_obs ? r1a : r0a;
    b = g_obs ? r1b : r0b;
    rsp_ready = (stall == 0);
    @(posedge clk); #1;
    ptr_m = ~g_obs[0];
    lat = 1;
    chk("ready_after_accept", 32'(req0_ready || req1_ready), 32'd0);
    chk("busy_after_accept", 32'(busy), 32'd1);
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat(b)));
    chk("rsp_data", rsp_data, exp_rot(a, b));
    chk("rsp_id", 32'(rsp_id), 32'(g_exp));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_data", rsp_data, exp_rot(a, b));
      chk("stall_id", 32'(rsp_id), 32'(g_exp));
      chk("stall_ready", 32'(req0_ready || req1_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("valid_drop", 32'(rsp_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b1;
    r0v = 1'b1; r0a = 32'h0000_00F0; r0b = 32'd4;
    r1v = 1'b1; r1a = 32'h0000_0001; r1b = 32'd1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Arbitration: both held valid, grants alternate 0,1,0,1
    serve(0);
    serve(0);
    serve(0);
    serve(0);

    // Basic rotate and zero / out-of-range amounts
    r1v = 1'b0; r0a = 32'h1234_56A5; r0b = 32'd3;
    serve(0);
    r0v = 1'b0; r1v = 1'b1; r1a = 32'hDEAD_BEEF; r1b = 32'd0;
    serve(0);
    r1b = 32'd9;
    serve(0);
    r1b = 32'h8000_0002;
    serve(0);

    // Backpressure with the other requester waiting
    r0v = 1'b1; r0a = 32'h0000_0081; r0b = 32'd7;
    r1v = 1'b1; r1a = 32'h0000_00FF; r1b = 32'd2;
    serve(5);

    // Max amount
    r1v = 1'b0; r0a = 32'hFFFF_FF01; r0b = 32'd7;
    serve(0);

    // Reset mid-rotate
    r0v = 1'b1; r0a = 32'h1234_5678; r0b = 32'd7; r1v = 1'b0;
    #1;
    chk("mid_rst_grant", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_rst_novalid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; r1v = 1'b1; r1a = 32'h0000_0010; r1b = 32'd4;
    #1;
    chk("rst_hi_ready", 32'(req0_ready || req1_ready), 32'd0);
    @(posedge clk); #1;
    chk("post_rst_valid", 32'(rsp_valid), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_data", rsp_data, 32'd0);
    rst = 1'b0; ptr_m = 1'b0;
    r0a = 32'h0000_0003; r0b = 32'd1;
    serve(0);
    serve(0);

    // Random operations against the reference model
    for (int n = 0; n < 40; n++) begin
      r0v = 1'($urandom_range(0, 1));
      r1v = r0v ? 1'($urandom_range(0, 1)) : 1'b1;
      r0a = $urandom; r1a = $urandom;
      r0b = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7));
      r1b = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7));
      serve($urandom_range(0, 2));
    end

    r0v = 1'b0; r1v = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
